// File: rtl/mips_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect/stall controls from
// the hazard/decode/execute logic, and the IF/ID register contents.
interface mips_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  // Fetch stage side
  modport master (
    output imem_addr, if_id_inst, if_id_pc_plus4, if_id_valid,
           fetch_fault, fetch_count,
    input  imem_inst, stall, branch_taken, branch_target,
           jump, jump_reg, jr_target
  );

  // Surrounding pipeline / memory side
  modport slave (
    input  imem_addr, if_id_inst, if_id_pc_plus4, if_id_valid,
           fetch_fault, fetch_count,
    output imem_inst, stall, branch_taken, branch_target,
           jump, jump_reg, jr_target
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: program counter, next-PC selection
// (branch > stall > jr > j > sequential), and the IF/ID pipeline register.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic          clk,
  input  logic          rst,
  mips_fetch_if.master  bus
);

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  // IF stage state
  logic [31:0] pc_p0;
  // IF/ID register
  logic [31:0] inst_p1;
  logic [31:0] pc_plus4_p1;
  logic        vld_p1;
  logic [31:0] count_p1;

  logic [31:0] pc_plus4_p0;
  logic [31:0] jump_target_p0;
  logic        fault_p0;
  logic [31:0] next_pc_p0;
  logic        flush_p0;
  logic        hold_p0;

  // J/JAL target: upper PC+4 nibble concatenated with the word index field
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] inst);
    return {pc_plus4[31:28], inst[25:0], 2'b00};
  endfunction

  // Fetch address is unusable when misaligned or past the end of memory
  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= IMEM_BYTES);
  endfunction

  assign pc_plus4_p0    = pc_p0 + 32'd4;
  assign jump_target_p0 = jump_target(pc_plus4_p1, inst_p1);
  assign fault_p0       = addr_fault(pc_p0);

  // Next-PC and IF/ID action; an older branch in EX beats a stall in ID,
  // and jumps only count when the ID-stage instruction is real
  always_comb begin
    next_pc_p0 = pc_plus4_p0;
    flush_p0   = 1'b0;
    hold_p0    = 1'b0;
    if (bus.branch_taken) begin
      next_pc_p0 = bus.branch_target;
      flush_p0   = 1'b1;
    end else if (bus.stall) begin
      next_pc_p0 = pc_p0;
      hold_p0    = 1'b1;
    end else if (bus.jump_reg && vld_p1) begin
      next_pc_p0 = bus.jr_target;
      flush_p0   = 1'b1;
    end else if (bus.jump && vld_p1) begin
      next_pc_p0 = jump_target_p0;
      flush_p0   = 1'b1;
    end
  end

  // Program counter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= next_pc_p0;
    end
  end

  // ---- IF -> ID boundary ----
  // IF/ID register: flush to a bubble, hold on stall, else capture the fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_p1     <= NOP_INST;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
      count_p1    <= 32'd0;
    end else if (flush_p0) begin
      inst_p1     <= NOP_INST;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
    end else if (!hold_p0) begin
      inst_p1     <= fault_p0 ? NOP_INST : bus.imem_inst;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= !fault_p0;
      if (!fault_p0) begin
        count_p1 <= count_p1 + 32'd1;
      end
    end
  end

  assign bus.imem_addr      = pc_p0;
  assign bus.fetch_fault    = fault_p0;
  assign bus.if_id_inst     = inst_p1;
  assign bus.if_id_pc_plus4 = pc_plus4_p1;
  assign bus.if_id_valid    = vld_p1;
  assign bus.fetch_count    = count_p1;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios followed by random control
// traffic, all checked against a transaction-level model of the fetch rules.
module tb_mips_fetch_stage;
  localparam int WORDS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_fetch_if bus();

  mips_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INST  (32'h0000_0000),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory; out-of-range reads return junk that must never be captured
  logic [31:0] mem [0:WORDS-1];
  assign bus.imem_inst = (bus.imem_addr[1:0] == 2'b00 && bus.imem_addr < 32'(WORDS * 4))
                         ? mem[bus.imem_addr[6:2]] : 32'hDEAD_BEEF;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_vld;

  function automatic bit fetchable(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(WORDS * 4));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_cnt = 32'h0;
  endtask

  // One clock of the fetch stage described as "what happens to the program flow"
  task automatic model_step(input bit st, input bit bt, input logic [31:0] btg,
                            input bit j, input bit jr, input logic [31:0] jrt);
    bit          redirect = 0;
    logic [31:0] target   = 32'h0;
    if (bt) begin
      redirect = 1; target = btg;
    end else if (st) begin
      return;
    end else if (jr && m_vld) begin
      redirect = 1; target = jrt;
    end else if (j && m_vld) begin
      redirect = 1;
      target = (m_pc4 & 32'hF000_0000) + (m_inst & 32'h03FF_FFFF) * 4;
    end
    if (redirect) begin
      m_inst = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_pc = target;
      return;
    end
    if (fetchable(m_pc)) begin
      m_inst = mem[m_pc / 4]; m_vld = 1'b1; m_cnt = m_cnt + 1;
    end else begin
      m_inst = 32'h0; m_vld = 1'b0;
    end
    m_pc4 = m_pc + 4;
    m_pc  = m_pc + 4;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  bus.imem_addr,      m_pc);
    chk({tag, ".fault"}, 32'(bus.fetch_fault), 32'(!fetchable(m_pc)));
    chk({tag, ".inst"},  bus.if_id_inst,     m_inst);
    chk({tag, ".pc4"},   bus.if_id_pc_plus4, m_pc4);
    chk({tag, ".valid"}, 32'(bus.if_id_valid), 32'(m_vld));
    chk({tag, ".count"}, bus.fetch_count,    m_cnt);
  endtask

  task automatic cyc(input string tag, input bit st, input bit bt, input logic [31:0] btg,
                     input bit j, input bit jr, input logic [31:0] jrt);
    @(negedge clk);
    bus.stall = st; bus.branch_taken = bt; bus.branch_target = btg;
    bus.jump = j; bus.jump_reg = jr; bus.jr_target = jrt;
    model_step(st, bt, btg, j, jr, jrt);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(9) < 8) return 32'($urandom_range(WORDS - 1)) * 32'd4;
    return 32'($urandom);
  endfunction

  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_reg = 0; bus.jr_target = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (i % 2 == 0) mem[i] = {6'h02, 21'd0, 5'($urandom_range(WORDS - 1))};
      else            mem[i] = 32'($urandom);
    end
    mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C; mem[3] = 32'hD000_000D;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    #1 rst = 1'b0;

    // Sequential fetch with a 2-cycle stall at pc=8
    cyc("run0", 0, 0, 0, 0, 0, 0);
    cyc("run1", 0, 0, 0, 0, 0, 0);
    chk("pc_before_stall", bus.imem_addr, 32'h8);
    chk("ifid_b", bus.if_id_inst, 32'hB000_000B);
    cyc("stall0", 1, 0, 0, 0, 0, 0);
    cyc("stall1", 1, 0, 0, 0, 0, 0);
    chk("stall_count", bus.fetch_count, 32'd2);
    cyc("run2", 0, 0, 0, 0, 0, 0);
    chk("ifid_c", bus.if_id_inst, 32'hC000_000C);
    cyc("run3", 0, 0, 0, 0, 0, 0);
    chk("count4", bus.fetch_count, 32'd4);

    // J at word 0 targeting 0x40; stalled jump must hold
    mem[0] = 32'h0800_0010;
    cyc("br0", 0, 1, 32'h0, 0, 0, 0);
    cyc("getj", 0, 0, 0, 0, 0, 0);
    chk("j_pc4", bus.if_id_pc_plus4, 32'd4);
    cyc("j_stalled", 1, 0, 0, 1, 0, 0);
    cyc("j_taken", 0, 0, 0, 1, 0, 0);
    chk("j_target", bus.imem_addr, 32'h40);
    chk("j_bubble", 32'(bus.if_id_valid), 32'd0);

    // Branch beats stall and jump
    cyc("fill", 0, 0, 0, 0, 0, 0);
    cyc("br_all", 1, 1, 32'h1C, 1, 0, 0);
    chk("br_target", bus.imem_addr, 32'h1C);

    // Faulting fetches via jr and branch, cleared by a branch to 0
    cyc("fill2", 0, 0, 0, 0, 0, 0);
    cyc("jr_mis", 0, 0, 0, 0, 1, 32'h7E);
    chk("fault_mis", 32'(bus.fetch_fault), 32'd1);
    cyc("cap_mis", 0, 0, 0, 0, 0, 0);
    cyc("br_oob", 0, 1, 32'h80, 0, 0, 0);
    chk("fault_oob", 32'(bus.fetch_fault), 32'd1);
    cyc("cap_oob", 0, 0, 0, 0, 0, 0);
    cyc("br_home", 0, 1, 32'h0, 0, 0, 0);
    chk("fault_clear", 32'(bus.fetch_fault), 32'd0);
    cyc("run_home", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset during a stall at pc=0x10
    cyc("br10", 0, 1, 32'h10, 0, 0, 0);
    cyc("st10a", 1, 0, 0, 0, 0, 0);
    cyc("st10b", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_held");
    #1 rst = 1'b0;
    cyc("after_rst", 0, 0, 0, 0, 0, 0);
    chk("first_from_reset_pc", bus.if_id_pc_plus4, 32'd4);

    // Random control traffic
    for (int k = 0; k < 400; k++) begin
      cyc("rand",
          $urandom_range(9) < 2, $urandom_range(9) < 1, rand_target(),
          $urandom_range(9) < 2, $urandom_range(9) < 1, rand_target());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
